// File: rtl/mem_arbiter.sv
// Arbitrates the shared memory port between I-cache line fills and D-cache fills/writes.
// Optional ARB_ROUND_ROBIN_EN: alternate ties between sides instead of fixed D-over-I priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int WORDS_PER_LINE = 8,
  localparam int WI            = $clog2(WORDS_PER_LINE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_grant_o,
  output logic [15:0]           i_data_o,
  output logic                  i_data_vld_o,
  output logic [WI-1:0]         i_word_o,
  output logic                  i_done_o,
  input  logic                  d_req_i,
  input  logic                  d_wr_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [15:0]           d_wdata_i,
  output logic                  d_grant_o,
  output logic [15:0]           d_data_o,
  output logic                  d_data_vld_o,
  output logic [WI-1:0]         d_word_o,
  output logic                  d_done_o,
  output logic                  mem_en_o,
  output logic                  mem_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [15:0]           mem_wdata_o,
  input  logic [15:0]           mem_rdata_i,
  input  logic                  mem_rvld_i
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(2 * WORDS_PER_LINE - 1);
  localparam logic [ADDR_WIDTH-1:0] HALF_MASK = ADDR_WIDTH'(1);
  localparam logic [WI-1:0]         LAST_WORD = WI'(WORDS_PER_LINE - 1);

  state_e                  state_q, state_d;
  logic                    i_grant_q, i_grant_d;
  logic                    d_grant_q, d_grant_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]             mem_wdata_q, mem_wdata_d;
  logic                    wr_done_q, wr_done_d;
  logic [WI-1:0]           iss_q, iss_d;
  logic [WI-1:0]           ret_q, ret_d;
  logic                    pick_d;
  logic                    fill_vld;
  logic                    ret_last;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when D won the most recent grant; resets to "I" so D takes the first tie.
  logic                    last_d_q, last_d_d;

  assign pick_d = d_req_i && (!i_req_i || !last_d_q);
`else
  assign pick_d = d_req_i;
`endif

  assign fill_vld = (state_q == FILL) && mem_rvld_i;
  assign ret_last = (ret_q == LAST_WORD);

  always_comb begin
    state_d     = state_q;
    i_grant_d   = i_grant_q;
    d_grant_d   = d_grant_q;
    mem_en_d    = mem_en_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_done_d   = 1'b0;
    iss_d       = iss_q;
    ret_d       = ret_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d    = last_d_q;
`endif

    case (state_q)
      IDLE: begin
        if (d_req_i || i_req_i) begin
          i_grant_d = !pick_d;
          d_grant_d = pick_d;
          mem_en_d  = 1'b1;
          iss_d     = '0;
          ret_d     = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d  = pick_d;
`endif
          if (pick_d && d_wr_i) begin
            state_d     = WRITE;
            mem_wr_d    = 1'b1;
            mem_addr_d  = d_addr_i & ~HALF_MASK;
            mem_wdata_d = d_wdata_i;
            wr_done_d   = 1'b1;
          end else begin
            state_d    = FILL;
            mem_wr_d   = 1'b0;
            mem_addr_d = (pick_d ? d_addr_i : i_addr_i) & ~LINE_MASK;
          end
        end
      end

      WRITE: begin
        state_d     = IDLE;
        i_grant_d   = 1'b0;
        d_grant_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_wdata_d = '0;
      end

      FILL: begin
        // Issue side runs ahead of the return side; the two counters are independent.
        if (mem_en_q) begin
          if (iss_q == LAST_WORD) begin
            mem_en_d = 1'b0;
          end else begin
            iss_d      = iss_q + WI'(1);
            mem_addr_d = mem_addr_q + ADDR_WIDTH'(2);
          end
        end
        if (mem_rvld_i) begin
          ret_d = ret_q + WI'(1);
          if (ret_last) begin
            state_d   = IDLE;
            i_grant_d = 1'b0;
            d_grant_d = 1'b0;
            mem_en_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        i_grant_d = 1'b0;
        d_grant_d = 1'b0;
        mem_en_d  = 1'b0;
        mem_wr_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      i_grant_q   <= 1'b0;
      d_grant_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_done_q   <= 1'b0;
      iss_q       <= '0;
      ret_q       <= '0;
    end else begin
      state_q     <= state_d;
      i_grant_q   <= i_grant_d;
      d_grant_q   <= d_grant_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_done_q   <= wr_done_d;
      iss_q       <= iss_d;
      ret_q       <= ret_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`endif

  // Return-side signals follow mem_rvld directly so they stay aligned with mem_rdata.
  assign i_data_vld_o = fill_vld && i_grant_q;
  assign d_data_vld_o = fill_vld && d_grant_q;
  assign i_data_o     = i_data_vld_o ? mem_rdata_i : '0;
  assign d_data_o     = d_data_vld_o ? mem_rdata_i : '0;
  assign i_word_o     = i_grant_q ? ret_q : '0;
  assign d_word_o     = d_grant_q ? ret_q : '0;
  assign i_done_o     = i_data_vld_o && ret_last;
  assign d_done_o     = wr_done_q || (d_data_vld_o && ret_last);

  assign i_grant_o   = i_grant_q;
  assign d_grant_o   = d_grant_q;
  assign mem_en_o    = mem_en_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
